// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register: owns the PC, splits
// two-word instructions into two beats and injects the interrupt slot.
module fetch_stage #(
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0]  INT_PC   = 32'h0000_0002
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [15:0]      InstrData,
    input  logic [15:0]      InPort,
    input  logic             IntReq,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             BranchTaken,
    input  logic [PC_W-1:0]  BranchTarget,
    output logic [PC_W-1:0]  InstrAddr,
    output logic [68:0]      Out
);

    // The interrupt slot is a one-edge action taken from RUN that always
    // returns to RUN, so it needs no state of its own in the register.
    typedef enum logic {
        ST_RUN,
        ST_IMM
    } state_t;

    typedef enum logic [1:0] {
        ACT_SQUASH,
        ACT_HOLD,
        ACT_INJECT,
        ACT_FETCH
    } act_t;

    state_t           state_q, state_d;
    act_t             act;
    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic             int_pend_q, int_pend_d;
    logic [68:0]      out_q, out_d;

    assign pc_inc    = pc_q + 1'b1;
    assign InstrAddr = pc_q;
    assign Out       = out_q;

    // Per-edge priority: squash/redirect, then stall, then interrupt at an
    // instruction boundary, then a normal fetch.
    always_comb begin
        // NOTE: default first so every path assigns act and no latch is inferred.
        act = ACT_FETCH;
        if (Flush || BranchTaken)
            act = ACT_SQUASH;
        else if (Stall)
            act = ACT_HOLD;
        else if (state_q == ST_RUN && int_pend_q)
            act = ACT_INJECT;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (act)
            ACT_SQUASH: state_d = ST_RUN;
            ACT_HOLD:   state_d = state_q;
            ACT_INJECT: state_d = ST_RUN;
            ACT_FETCH:  state_d = (state_q == ST_RUN && InstrData[0]) ? ST_IMM : ST_RUN;
        endcase
    end

    // Output / datapath logic: next PC, next bundle, pending interrupt.
    always_comb begin
        pc_d       = pc_q;
        out_d      = out_q;
        int_pend_d = int_pend_q | IntReq;
        case (act)
            ACT_SQUASH: begin
                out_d = '0;
                if (BranchTaken)
                    pc_d = BranchTarget;
            end
            ACT_HOLD: begin
                pc_d  = pc_q;
                out_d = out_q;
            end
            ACT_INJECT: begin
                out_d      = {InPort, pc_q, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00};
                pc_d       = INT_PC;
                int_pend_d = IntReq;
            end
            ACT_FETCH: begin
                out_d = {InPort, pc_inc, InstrData, 1'b0, 1'b1,
                         (state_q == ST_IMM), 2'b00};
                pc_d  = pc_inc;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: the bundle register is reset as well, so decode never sees a stale valid beat.
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            int_pend_q <= 1'b0;
            out_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            int_pend_q <= int_pend_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, two-word split,
// stall, interrupt injection, redirect, PC wrap and asynchronous reset.
module tb_fetch_stage;

    logic        Clk;
    logic        Rst;
    logic [15:0] InstrData;
    logic [15:0] InPort;
    logic        IntReq;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InstrAddr;
    logic [68:0] Out;

    int checks   = 0;
    int failures = 0;

    // Instruction memory, indexed by the low address byte.
    logic [15:0] mem [0:255];
    assign InstrData = mem[InstrAddr[7:0]];

    fetch_stage #(
        .PC_W    (32),
        .RESET_PC(32'h0000_0000),
        .INT_PC  (32'h0000_0002)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InstrData   (InstrData),
        .InPort      (InPort),
        .IntReq      (IntReq),
        .Stall       (Stall),
        .Flush       (Flush),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrAddr   (InstrAddr),
        .Out         (Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [68:0] bundle(input logic [15:0] ip, input logic [31:0] ra,
                                           input logic [15:0] w, input logic intr,
                                           input logic valid, input logic imm);
        return {ip, ra, w, intr, valid, imm, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1000; mem[1]  = 16'h2000; mem[2]  = 16'h3000;
        mem[5]   = 16'h4001; mem[6]  = 16'h00AB;
        mem[10]  = 16'h5A5A;
        mem[20]  = 16'h0010; mem[21] = 16'h0022;
        mem[30]  = 16'h7001; mem[31] = 16'h00CD; mem[32] = 16'h0100;
        mem[255] = 16'h0EEE;

        Rst = 1'b0; InPort = 16'hA5A5; IntReq = 1'b0; Stall = 1'b0;
        Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;

        // Reset state
        step(); step();
        check("reset_out",  Out, 69'h0);
        check("reset_addr", {37'h0, InstrAddr}, 69'h0);
        Rst = 1'b1;

        // Sequential fetch from RESET_PC
        step(); check("seq0", Out, bundle(16'hA5A5, 32'd1, 16'h1000, 0, 1, 0));
        step(); check("seq1", Out, bundle(16'hA5A5, 32'd2, 16'h2000, 0, 1, 0));
        step(); check("seq2", Out, bundle(16'hA5A5, 32'd3, 16'h3000, 0, 1, 0));
        check("seq_addr", {37'h0, InstrAddr}, 69'd3);

        // Two-word instruction at PC 5
        step(); step();
        InPort = 16'h0F0F;
        step(); check("imm_first",  Out, bundle(16'h0F0F, 32'd6, 16'h4001, 0, 1, 0));
        step(); check("imm_second", Out, bundle(16'h0F0F, 32'd7, 16'h00AB, 0, 1, 1));
        check("imm_addr", {37'h0, InstrAddr}, 69'd7);
        step(); check("imm_no_third", Out, bundle(16'h0F0F, 32'd8, 16'h0000, 0, 1, 0));

        // Stall at PC 10 for three cycles, then resume with PC 10's word
        step(); step();
        Stall = 1'b1; InPort = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_out",  Out, bundle(16'h0F0F, 32'd10, 16'h0000, 0, 1, 0));
            check("stall_addr", {37'h0, InstrAddr}, 69'd10);
        end
        Stall = 1'b0;
        step(); check("stall_resume", Out, bundle(16'h1234, 32'd11, 16'h5A5A, 0, 1, 0));

        // Interrupt request during a stall is injected on the first free edge
        Stall = 1'b1; IntReq = 1'b1;
        step(); IntReq = 1'b0;
        step(); check("stall_int_hold", Out, bundle(16'h1234, 32'd11, 16'h5A5A, 0, 1, 0));
        Stall = 1'b0;
        step(); check("stall_int_slot", Out, bundle(16'h1234, 32'd11, 16'h0000, 1, 1, 0));
        check("stall_int_addr", {37'h0, InstrAddr}, 69'd2);
        step(); check("after_int", Out, bundle(16'h1234, 32'd3, 16'h3000, 0, 1, 0));

        // Redirect to 20, then interrupt while fetching PC 20
        BranchTaken = 1'b1; BranchTarget = 32'd20;
        step(); check("redir_bubble", Out, 69'h0);
        check("redir_addr", {37'h0, InstrAddr}, 69'd20);
        BranchTaken = 1'b0; IntReq = 1'b1;
        step(); check("int_fetch20", Out, bundle(16'h1234, 32'd21, 16'h0010, 0, 1, 0));
        IntReq = 1'b0;
        step(); check("int_slot21", Out, bundle(16'h1234, 32'd21, 16'h0000, 1, 1, 0));
        check("int_pc", {37'h0, InstrAddr}, 69'd2);

        // Request at a two-word instruction: injection waits for the IMM beat
        BranchTaken = 1'b1; BranchTarget = 32'd30;
        step(); BranchTaken = 1'b0; IntReq = 1'b1;
        step(); check("imm_int_first", Out, bundle(16'h1234, 32'd31, 16'h7001, 0, 1, 0));
        IntReq = 1'b0;
        step(); check("imm_int_beat", Out, bundle(16'h1234, 32'd32, 16'h00CD, 0, 1, 1));
        step(); check("imm_int_slot", Out, bundle(16'h1234, 32'd32, 16'h0000, 1, 1, 0));

        // Redirect coinciding with an interrupt request
        BranchTaken = 1'b1; BranchTarget = 32'h100; IntReq = 1'b1;
        step(); check("redir_int_bubble", Out, 69'h0);
        check("redir_int_addr", {37'h0, InstrAddr}, 69'h100);
        BranchTaken = 1'b0; IntReq = 1'b0;
        step(); check("redir_int_slot", Out, bundle(16'h1234, 32'h100, 16'h0000, 1, 1, 0));

        // Stall and Flush together: flush wins, PC unchanged
        Stall = 1'b1; Flush = 1'b1;
        step(); check("flush_stall_out", Out, 69'h0);
        check("flush_stall_addr", {37'h0, InstrAddr}, 69'd2);
        Stall = 1'b0; Flush = 1'b0;

        // PC wrap at 32'hFFFF_FFFF
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFF;
        step(); BranchTaken = 1'b0;
        step(); check("wrap_out", Out, bundle(16'h1234, 32'h0, 16'h0EEE, 0, 1, 0));
        check("wrap_addr", {37'h0, InstrAddr}, 69'h0);

        // Asynchronous reset between edges while mid two-word instruction
        mem[0] = 16'h1001;
        step(); check("pre_reset_imm", Out, bundle(16'h1234, 32'd1, 16'h1001, 0, 1, 0));
        #3 Rst = 1'b0;
        #1;
        check("async_out",  Out, 69'h0);
        check("async_addr", {37'h0, InstrAddr}, 69'h0);
        step();
        Rst = 1'b1;
        step(); check("post_reset_run", Out, bundle(16'h1234, 32'd1, 16'h1001, 0, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register: the producer of the 69-bit fetch bundle that the decode stage consumes. Holds the PC, drives instruction-memory addresses, splits two-word (immediate-carrying) instructions into two beats, injects the interrupt slot, and obeys the stall, flush and redirect requests coming back from decode and execute.

## Interface
- PC_W, 32, PC / instruction-address width (must be 32 to match bundle bits [52:21])
- RESET_PC, 32'h0000_0000, PC value after reset
- INT_PC, 32'h0000_0002, PC loaded when the interrupt slot is injected
- Clk  input  1  clock; all state updates on the rising edge
- Rst  input  1  reset, asynchronous, active-low
- InstrData  input  16  instruction word at InstrAddr, valid in the same cycle (combinational memory read)
- InPort  input  16  external input port, sampled with each fetched beat
- IntReq  input  1  external interrupt request, sampled every cycle
- Stall  input  1  hold request from decode (decode bundle stall bit)
- Flush  input  1  squash request from decode/execute (decode bundle flush bit)
- BranchTaken  input  1  PC redirect request
- BranchTarget  input  32  redirect address, used only when BranchTaken=1
- InstrAddr  output  32  current PC to instruction memory (combinational from PC register)
- Out  output  69  registered fetch bundle: [68:53] InPort, [52:21] return address, [20:5] instruction word, [4] interrupt slot, [3] valid, [2] immediate beat, [1:0] zero

## Operation
- State: PC (32), state ∈ {RUN, IMM, INT}, IntPend (1), Out register (69).
- Two-word rule: a word in RUN with InstrData[0]=1 announces an immediate in the next word.
- RUN, no stall/flush/redirect: Out ← {InPort, PC+1, InstrData, 0, 1, 0, 00}; PC ← PC+1; go IMM if InstrData[0]=1, else stay RUN.
- IMM: Out ← {InPort, PC+1, InstrData, 0, 1, 1, 00}; PC ← PC+1; go RUN. Immediate bit [0] of this word is ignored.
- INT: entered from RUN when IntPend=1 at an instruction boundary (state RUN, no stall/flush/redirect). In that cycle no instruction is consumed: Out ← {InPort, PC, 16'h0000, 1, 1, 0, 00} (return address = PC of the not-yet-executed instruction); PC ← INT_PC; IntPend ← 0; next state RUN. INT lasts exactly one cycle.
- IntPend: set on any cycle with IntReq=1; a single pending request. Further requests while pending are merged. Cleared only on injection.
- Priority per edge, highest first: Rst; Flush/BranchTaken; Stall; interrupt injection; normal fetch.
- Flush=1: Out ← 0 (bubble, valid=0); state ← RUN (an in-flight IMM beat is discarded). PC ← BranchTarget if BranchTaken else unchanged.
- BranchTaken=1 without Flush: same as Flush (redirect always squashes the wrong-path word).
- Stall=1 (no flush/redirect): PC, state and Out hold. IntPend may still set.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 = 0. Return address likewise wraps.

## Timing
- Reset (Rst=0, asynchronous): PC=RESET_PC, state=RUN, IntPend=0, Out=69'h0. InstrAddr=RESET_PC immediately.
- First valid beat: on the first rising edge after Rst deasserts, Out carries word at RESET_PC.
- Latency: InstrAddr → Out is one edge; InstrAddr changes the same edge Out updates.
- Interrupt latency: IntReq high at edge N is seen at N; injection occurs at the first later edge meeting the boundary condition (minimum N+1; +1 extra if the current beat is IMM; + stall cycles).
- IntReq coinciding with redirect: redirect wins, IntPend still sets, injection after the redirect edge, return address = BranchTarget.
- Stall and Flush together: Flush wins.
- Rst asserted mid-IMM or mid-stall: immediate return to reset values, no partial beat emitted.

## Test plan
- Reset/sequence: Rst low then high, memory words 0x1000,0x2000,0x3000 at 0,1,2 -> Out[20:5]=0x1000,0x2000,0x3000 on edges 1-3, Out[52:21]=1,2,3, Out[3]=1, Out[2]=0.
- Two-word: word 0x4001 at PC 5 then 0x00AB -> beats {0x4001, Out[2]=0} then {0x00AB, Out[2]=1}; 0x00AB's bit0 does not trigger a third beat; PC=7 after.
- Stall: Stall high 3 cycles at PC 10 -> Out and InstrAddr frozen 3 cycles, resume with PC 10's word; IntReq pulse during stall injected right after.
- Interrupt: IntReq pulse while fetching PC 20 (single-word) -> next beat Out[4]=1, Out[20:5]=0, Out[52:21]=21, then InstrAddr=INT_PC; pulse during IMM beat delays injection by one cycle.
- Redirect: BranchTaken=1, BranchTarget=0x100 with IntReq same cycle -> Out=0 bubble, InstrAddr=0x100, then interrupt slot with Out[52:21]=0x100.
- Wrap and async reset: PC=32'hFFFF_FFFF fetch -> return address 0, InstrAddr 0; drop Rst mid-IMM between edges -> Out=0, InstrAddr=RESET_PC without waiting for Clk.
